// File: rtl/xillybus_axi_slice.sv
// AXI3 master-side pipeline stage: a registered two-entry skid buffer on every channel,
// outstanding-burst limiters for reads and writes, and a sticky non-OKAY response flag.

module xillybus_axi_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         ready_r;
  logic         in_fire;

  assign in_fire   = in_valid & ready_r;
  assign in_ready  = ready_r;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // ready_r is always "skid register will be empty"; it rises the edge the skid drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_r    <= 1'b0;
    end else begin
      if (!main_valid || out_ready) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= in_fire;
          if (in_fire) main_data <= in_data;
        end
        ready_r <= 1'b1;
      end else if (in_fire) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
        ready_r    <= 1'b0;
      end else begin
        ready_r <= ~skid_valid;
      end
    end
  end

endmodule

module xillybus_axi_slice #(
  parameter int C_M_AXI_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_DATA_WIDTH   = 64,
  parameter int C_MAX_OUTSTANDING_RD = 4,
  parameter int C_MAX_OUTSTANDING_WR = 4,
  localparam int AXW = C_M_AXI_ADDR_WIDTH + 16,
  localparam int RW  = C_M_AXI_DATA_WIDTH + 3,
  localparam int WW  = C_M_AXI_DATA_WIDTH + C_M_AXI_DATA_WIDTH / 8 + 1
) (
  input  logic           m_axi_aclk,
  input  logic           m_axi_aresetn,
  input  logic           s_ar_valid,
  output logic           s_ar_ready,
  input  logic [AXW-1:0] s_ar_payload,
  output logic           m_ar_valid,
  input  logic           m_ar_ready,
  output logic [AXW-1:0] m_ar_payload,
  input  logic           m_r_valid,
  output logic           m_r_ready,
  input  logic [RW-1:0]  m_r_payload,
  output logic           s_r_valid,
  input  logic           s_r_ready,
  output logic [RW-1:0]  s_r_payload,
  input  logic           s_aw_valid,
  output logic           s_aw_ready,
  input  logic [AXW-1:0] s_aw_payload,
  output logic           m_aw_valid,
  input  logic           m_aw_ready,
  output logic [AXW-1:0] m_aw_payload,
  input  logic           s_w_valid,
  output logic           s_w_ready,
  input  logic [WW-1:0]  s_w_payload,
  output logic           m_w_valid,
  input  logic           m_w_ready,
  output logic [WW-1:0]  m_w_payload,
  input  logic           m_b_valid,
  output logic           m_b_ready,
  input  logic [1:0]     m_b_payload,
  output logic           s_b_valid,
  input  logic           s_b_ready,
  output logic [1:0]     s_b_payload,
  output logic [3:0]     rd_outstanding,
  output logic [3:0]     wr_outstanding,
  output logic           err_sticky,
  input  logic           err_clr
);

  logic       ar_buf_ready, aw_buf_ready;
  logic       rd_room, wr_room;
  logic       ar_hs, aw_hs, r_last_hs, b_hs;
  logic       r_err, b_err;
  logic [3:0] rd_cnt, wr_cnt;

  // Limiter gating is combinational so the stall lands in the cycle the count hits max.
  assign rd_room    = rd_cnt < 4'(C_MAX_OUTSTANDING_RD);
  assign wr_room    = wr_cnt < 4'(C_MAX_OUTSTANDING_WR);
  assign s_ar_ready = ar_buf_ready & rd_room;
  assign s_aw_ready = aw_buf_ready & wr_room;

  xillybus_axi_slice_skid #(.W(AXW)) u_ar (
    .clk(m_axi_aclk), .rst_n(m_axi_aresetn),
    .in_valid(s_ar_valid & rd_room), .in_ready(ar_buf_ready), .in_data(s_ar_payload),
    .out_valid(m_ar_valid), .out_ready(m_ar_ready), .out_data(m_ar_payload)
  );

  xillybus_axi_slice_skid #(.W(RW)) u_r (
    .clk(m_axi_aclk), .rst_n(m_axi_aresetn),
    .in_valid(m_r_valid), .in_ready(m_r_ready), .in_data(m_r_payload),
    .out_valid(s_r_valid), .out_ready(s_r_ready), .out_data(s_r_payload)
  );

  xillybus_axi_slice_skid #(.W(AXW)) u_aw (
    .clk(m_axi_aclk), .rst_n(m_axi_aresetn),
    .in_valid(s_aw_valid & wr_room), .in_ready(aw_buf_ready), .in_data(s_aw_payload),
    .out_valid(m_aw_valid), .out_ready(m_aw_ready), .out_data(m_aw_payload)
  );

  xillybus_axi_slice_skid #(.W(WW)) u_w (
    .clk(m_axi_aclk), .rst_n(m_axi_aresetn),
    .in_valid(s_w_valid), .in_ready(s_w_ready), .in_data(s_w_payload),
    .out_valid(m_w_valid), .out_ready(m_w_ready), .out_data(m_w_payload)
  );

  xillybus_axi_slice_skid #(.W(2)) u_b (
    .clk(m_axi_aclk), .rst_n(m_axi_aresetn),
    .in_valid(m_b_valid), .in_ready(m_b_ready), .in_data(m_b_payload),
    .out_valid(s_b_valid), .out_ready(s_b_ready), .out_data(s_b_payload)
  );

  assign ar_hs     = s_ar_valid & s_ar_ready;
  assign aw_hs     = s_aw_valid & s_aw_ready;
  assign r_last_hs = s_r_valid & s_r_ready & s_r_payload[0];
  assign b_hs      = s_b_valid & s_b_ready;
  assign r_err     = s_r_valid & s_r_ready & (s_r_payload[2:1] != 2'b00);
  assign b_err     = b_hs & (s_b_payload != 2'b00);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      rd_cnt     <= 4'd0;
      wr_cnt     <= 4'd0;
      err_sticky <= 1'b0;
    end else begin
      case ({ar_hs, r_last_hs})
        2'b10:   rd_cnt <= rd_cnt + 4'd1;
        2'b01:   rd_cnt <= rd_cnt - 4'd1;
        default: rd_cnt <= rd_cnt;
      endcase
      case ({aw_hs, b_hs})
        2'b10:   wr_cnt <= wr_cnt + 4'd1;
        2'b01:   wr_cnt <= wr_cnt - 4'd1;
        default: wr_cnt <= wr_cnt;
      endcase
      if (r_err || b_err)
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;
    end
  end

  assign rd_outstanding = rd_cnt;
  assign wr_outstanding = wr_cnt;

endmodule

// File: tb/tb_xillybus_axi_slice.sv
// Directed self-checking bench for xillybus_axi_slice with default parameters
// (AW=32, DW=64, four outstanding bursts each way).

module tb_xillybus_axi_slice;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
  logic [47:0] s_ar_payload, m_ar_payload;
  logic        m_r_valid, m_r_ready, s_r_valid, s_r_ready;
  logic [66:0] m_r_payload, s_r_payload;
  logic        s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
  logic [47:0] s_aw_payload, m_aw_payload;
  logic        s_w_valid, s_w_ready, m_w_valid, m_w_ready;
  logic [72:0] s_w_payload, m_w_payload;
  logic        m_b_valid, m_b_ready, s_b_valid, s_b_ready;
  logic [1:0]  m_b_payload, s_b_payload;
  logic [3:0]  rd_outstanding, wr_outstanding;
  logic        err_sticky, err_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xillybus_axi_slice dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_payload(s_ar_payload),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_payload(m_ar_payload),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_payload(m_r_payload),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_payload(s_r_payload),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_payload(s_aw_payload),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_payload(m_aw_payload),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_payload(s_w_payload),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_payload(m_w_payload),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_payload(m_b_payload),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_payload(s_b_payload),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [47:0] apl(input logic [31:0] addr);
    return {addr, 4'd3, 3'd3, 2'd1, 3'd0, 4'd3};
  endfunction

  function automatic logic [66:0] rpl(input int k, input logic [1:0] resp, input logic last);
    return {64'hDEAD_0000_0000_0000 + 64'(k), resp, last};
  endfunction

  function automatic logic [72:0] wpl(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'(i * 7 + 1), 8'(i ^ 8'h5A), i[0]};
  endfunction

  initial begin
    s_ar_valid = 0; s_ar_payload = '0; m_ar_ready = 0;
    m_r_valid = 0; m_r_payload = '0; s_r_ready = 0;
    s_aw_valid = 0; s_aw_payload = '0; m_aw_ready = 0;
    s_w_valid = 0; s_w_payload = '0; m_w_ready = 0;
    m_b_valid = 0; m_b_payload = '0; s_b_ready = 0;
    err_clr = 0;

    // Reset values
    step();
    chk("rst_valids", {m_ar_valid, s_r_valid, m_aw_valid, m_w_valid, s_b_valid}, 0);
    chk("rst_readies", {s_ar_ready, m_r_ready, s_aw_ready, s_w_ready, m_b_ready}, 0);
    chk("rst_counts", {rd_outstanding, wr_outstanding, err_sticky}, 0);
    chk("rst_payload", {m_ar_payload, m_w_payload}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rdy_after_rst", {s_ar_ready, m_r_ready, s_aw_ready, s_w_ready, m_b_ready}, 5'b11111);

    // Streaming 256 W beats, no bubbles
    m_w_ready = 1;
    s_w_valid = 1;
    s_w_payload = wpl(0);
    for (int i = 1; i <= 256; i++) begin
      step();
      chk("w_stream_valid", {m_w_valid, s_w_ready}, 2'b11);
      chk("w_stream_data", m_w_payload, wpl(i - 1));
      if (i < 256) s_w_payload = wpl(i);
      else s_w_valid = 0;
    end
    step();
    chk("w_stream_end", m_w_valid, 1'b0);
    m_w_ready = 0;

    // Back-pressure on AR
    do_reset();
    s_ar_valid = 1;
    s_ar_payload = apl(32'h100);
    step();
    chk("bp_first_out", {m_ar_valid, m_ar_payload}, {1'b1, apl(32'h100)});
    s_ar_payload = apl(32'h200);
    step();
    chk("bp_skid_full", s_ar_ready, 1'b0);
    chk("bp_rd_cnt", rd_outstanding, 4'd2);
    s_ar_payload = apl(32'h300);
    step();
    chk("bp_hold", {s_ar_ready, m_ar_payload}, {1'b0, apl(32'h100)});
    m_ar_ready = 1;
    step();
    chk("bp_second", {m_ar_valid, m_ar_payload, s_ar_ready}, {1'b1, apl(32'h200), 1'b1});
    step();
    chk("bp_third", {m_ar_valid, m_ar_payload, rd_outstanding}, {1'b1, apl(32'h300), 4'd3});
    s_ar_valid = 0;
    step();
    chk("bp_drained", m_ar_valid, 1'b0);

    // Read limit
    do_reset();
    m_ar_ready = 1;
    s_r_ready = 1;
    s_ar_valid = 1;
    for (int i = 0; i < 4; i++) begin
      s_ar_payload = apl(32'h1000 + 32'(i * 16));
      step();
    end
    s_ar_payload = apl(32'h5000);
    chk("lim_count4", {rd_outstanding, s_ar_ready}, {4'd4, 1'b0});
    step();
    chk("lim_stalled", {rd_outstanding, s_ar_ready}, {4'd4, 1'b0});
    m_r_valid = 1;
    for (int k = 0; k < 4; k++) begin
      m_r_payload = rpl(k, 2'b00, k == 3);
      step();
      chk("r_beat", {s_r_valid, s_r_payload}, {1'b1, rpl(k, 2'b00, k == 3)});
    end
    m_r_valid = 0;
    chk("lim_before_last", rd_outstanding, 4'd4);
    step();
    chk("lim_after_last", {rd_outstanding, s_ar_ready}, {4'd3, 1'b1});
    step();
    chk("lim_fifth_acc", {rd_outstanding, m_ar_valid, m_ar_payload}, {4'd4, 1'b1, apl(32'h5000)});
    s_ar_valid = 0;
    chk("lim_err_clean", err_sticky, 1'b0);

    // Simultaneous AW and B handshakes
    do_reset();
    m_aw_ready = 1;
    s_b_ready = 1;
    s_aw_valid = 1;
    s_aw_payload = apl(32'h2000);
    step();
    s_aw_payload = apl(32'h2040);
    step();
    s_aw_valid = 0;
    m_b_valid = 1;
    m_b_payload = 2'b00;
    step();
    chk("sim_pre", {wr_outstanding, s_b_valid}, {4'd2, 1'b1});
    m_b_valid = 0;
    s_aw_valid = 1;
    s_aw_payload = apl(32'h2080);
    step();
    chk("sim_both", {wr_outstanding, s_b_valid}, {4'd2, 1'b0});
    s_aw_valid = 0;

    // Sticky error
    m_b_valid = 1;
    m_b_payload = 2'b10;
    step();
    m_b_valid = 0;
    chk("err_b_pending", {err_sticky, s_b_payload}, {1'b0, 2'b10});
    step();
    chk("err_b_set", err_sticky, 1'b1);
    m_r_valid = 1;
    m_r_payload = rpl(9, 2'b11, 1'b0);
    step();
    m_r_valid = 0;
    err_clr = 1;
    step();
    err_clr = 0;
    chk("err_set_wins", err_sticky, 1'b1);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("err_cleared", err_sticky, 1'b0);
    m_aw_ready = 0;
    s_b_ready = 0;
    s_r_ready = 0;

    // Reset asserted mid-operation
    do_reset();
    m_ar_ready = 1;
    s_ar_valid = 1;
    for (int i = 0; i < 3; i++) begin
      s_ar_payload = apl(32'hA00 + 32'(i * 4));
      step();
    end
    s_ar_valid = 0;
    s_aw_valid = 1;
    s_aw_payload = apl(32'hB00);
    step();
    s_aw_payload = apl(32'hB04);
    step();
    s_aw_valid = 0;
    chk("mid_state", {rd_outstanding, wr_outstanding, m_aw_valid, s_aw_ready}, {4'd3, 4'd2, 1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valids", {m_ar_valid, s_r_valid, m_aw_valid, m_w_valid, s_b_valid}, 0);
    chk("mid_rst_readies", {s_ar_ready, m_r_ready, s_aw_ready, s_w_ready, m_b_ready}, 0);
    chk("mid_rst_counts", {rd_outstanding, wr_outstanding, m_aw_payload}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_before_edge", s_aw_ready, 1'b0);
    step();
    chk("mid_rel_readies", {s_ar_ready, m_r_ready, s_aw_ready, s_w_ready, m_b_ready}, 5'b11111);
    chk("mid_rel_empty", {m_aw_valid, wr_outstanding}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xillybus_axi_slice.md
# xillybus_axi_slice

Parametrised AXI3 master-side pipeline stage between the Xillybus core's DMA master and the processor's AXI slave port. Each of the five channels (AR, R, AW, W, B) passes through a two-entry skid buffer, which breaks every combinational valid/ready path. The block also limits the number of outstanding read and write bursts, reports occupancy counters, and holds a sticky error flag for non-OKAY responses. Channel payloads are packed vectors; "core side" (`s_*`) faces the Xillybus core and "port side" (`m_*`) faces the processor.

## Interface
Parameters:
- `C_M_AXI_ADDR_WIDTH`, 32, address width (AW)
- `C_M_AXI_DATA_WIDTH`, 64, data width (DW), multiple of 8
- `C_MAX_OUTSTANDING_RD`, 4, maximum read bursts in flight, 1..15
- `C_MAX_OUTSTANDING_WR`, 4, maximum write bursts in flight, 1..15

Payload packing, MSB first:
- AR/AW: {addr[AW], len[4], size[3], burst[2], prot[3], cache[4]}, width AW+16
- R: {data[DW], resp[2], last}, width DW+3
- W: {data[DW], strb[DW/8], last}, width DW+DW/8+1
- B: {resp[2]}

Ports:
- `m_axi_aclk`  in  1  sole clock
- `m_axi_aresetn`  in  1  asynchronous active-low reset
- `s_ar_valid`/`s_ar_ready`/`s_ar_payload`  in/out/in  1/1/AW+16  AR from core
- `m_ar_valid`/`m_ar_ready`/`m_ar_payload`  out/in/out  AR to port
- `m_r_valid`/`m_r_ready`/`m_r_payload`  in/out/in  1/1/DW+3  R from port
- `s_r_valid`/`s_r_ready`/`s_r_payload`  out/in/out  R to core
- `s_aw_*`, `m_aw_*`  same shape as AR
- `s_w_*`, `m_w_*`  same shape, W payload width
- `m_b_valid`/`m_b_ready`/`m_b_payload`  in/out/in  1/1/2  B from port
- `s_b_valid`/`s_b_ready`/`s_b_payload`  out/in/out  B to core
- `rd_outstanding`  out  4  read bursts in flight
- `wr_outstanding`  out  4  write bursts in flight
- `err_sticky`  out  1  a non-OKAY R or B response has been seen
- `err_clr`  in  1  single-cycle clear of `err_sticky`

## Operation
- Each channel uses a skid buffer with a main register and a skid register.
  - Upstream ready is registered and equals "skid register empty".
  - Downstream valid is registered and equals "main register full".
  - Payload is unchanged and order is preserved.
- Read limiter:
  - `s_ar_ready` = buffer ready AND `rd_outstanding` < `C_MAX_OUTSTANDING_RD`.
  - `rd_outstanding` increments on an `s_ar` handshake.
  - It decrements on an `s_r` handshake with last=1.
  - A simultaneous increment and decrement leaves the count unchanged.
- Write limiter:
  - `s_aw_ready` is gated the same way against `C_MAX_OUTSTANDING_WR`.
  - `wr_outstanding` increments on an `s_aw` handshake and decrements on an `s_b` handshake.
  - The W channel is not gated; W beats may precede AW.
- Counter wrap is impossible by construction; no saturating logic is required.
- `err_sticky` sets on an `s_r` or `s_b` handshake whose resp is not 2'b00. `err_clr` clears it. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values while `m_axi_aresetn` is low:
  - All `*_valid` outputs 0, all `*_ready` outputs 0.
  - Counters 0, `err_sticky` 0, payload outputs 0.
- After reset release, all readies rise at the first rising edge.
- Latency through an empty buffer is 1 cycle: input handshake at edge N, output valid from edge N+1.
- Throughput is 1 beat/cycle when downstream ready stays high.
- On a downstream stall, one further beat is absorbed into the skid register. Upstream ready drops at the next edge. No beat is lost or duplicated.
- When downstream ready returns, the skid register drains before any new input is accepted, and ready rises one cycle later.
- A limiter stall takes effect combinationally in the same cycle the counter reaches its maximum. The release after a decrement is visible one cycle after the decrementing handshake.
- Reset asserted mid-burst discards all buffered beats and counters immediately. No recovery of in-flight transactions is attempted.

## Test plan
- Streaming: 256 W beats with both sides always ready -> 256 beats out with identical payload, 1-cycle latency, no bubbles.
- Back-pressure: hold `m_ar_ready` low while presenting 3 ARs (addresses 0x100, 0x200, 0x300) -> 2 absorbed and `s_ar_ready`=0. On release, addresses emerge in order 0x100, 0x200, then 0x300 is accepted.
- Read limit (MAX_RD=4): issue 5 ARs with R held off -> `rd_outstanding`=4 and the 5th is stalled. Return one 4-beat burst (last on beat 4) -> count becomes 3 and the 5th AR is accepted on the next cycle.
- Simultaneous events: AW handshake and B handshake in the same cycle at `wr_outstanding`=2 -> count stays 2.
- Errors: B resp=2'b10 -> `err_sticky`=1 next cycle. `err_clr` together with an R resp=2'b11 -> remains 1. `err_clr` alone -> 0.
- Reset mid-operation: assert reset with 2 beats buffered and counts at 3 -> all valids, readies and counters 0 asynchronously. Readies return to 1 one edge after release.
